instructie_decoder_pipe: RTL and testbench
==========================================

Name: instructie_decoder_pipe

Overview:
- Parametrised, handshaked successor to the single-word instruction decoder.
- Splits each instruction word into an opcode field and an operand field, and maps each legal opcode k to decoded code k+1; code 0 means "no/illegal instruction".
- Supports two-word instructions: a flagged opcode is followed by an immediate word. An illegal-opcode flag and a saturating illegal-instruction counter are added.
- Sits between the fetch stage and the execute/control unit.

Parameters:
- INSTR_W, 9: instruction word width.
- OPC_W, 4: opcode field width. The opcode is taken from the top bits, instructie[INSTR_W-1 -: OPC_W].
- NUM_OPS, 7: number of legal opcodes (0..NUM_OPS-1). Must be <= 2^OPC_W - 1.
- IMM_MASK, 16'h0060: width 2^OPC_W. Bit k set means opcode k is followed by one immediate word.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clock, in, 1: all registers update on the falling edge.
- reset_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous discard of in-flight decode state.
- in_valid, in, 1: instructie is valid.
- in_ready, out, 1: decoder accepts a word this cycle.
- instructie, in, INSTR_W: instruction or immediate word.
- out_valid, out, 1: decoded output register is full.
- out_ready, in, 1: consumer takes the output.
- out_code, out, OPC_W+1: opcode+1, or 0 when illegal.
- out_operand, out, INSTR_W-OPC_W: operand field, instructie[INSTR_W-OPC_W-1:0].
- out_imm, out, INSTR_W: immediate word, 0 if none.
- out_has_imm, out, 1: out_imm is meaningful.
- out_illegal, out, 1: opcode >= NUM_OPS.
- illegal_count, out, CNT_W: saturating count of illegal opcodes.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=S_OPC; hold registers cleared.
  - out_valid, out_code, out_operand, out_imm, out_has_imm, out_illegal and illegal_count all 0.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and is 1 immediately after reset.
- accept = in_valid && in_ready. A word is consumed exactly once per accept edge.
- State S_OPC, on accept, with op = opcode field:
  - op >= NUM_OPS: load output with code=0, operand field, imm=0, has_imm=0, illegal=1. illegal_count increments, saturating at all-ones. Stay in S_OPC.
  - Legal op with IMM_MASK[op]=0: load output with code=op+1, operand, imm=0, has_imm=0, illegal=0. Stay in S_OPC.
  - Legal op with IMM_MASK[op]=1: latch op and operand into the hold register. The output register is not loaded. Go to S_IMM.
- State S_IMM, on accept: load output with code=held op+1, held operand, imm=instructie, has_imm=1, illegal=0. Go to S_OPC. The immediate word is never opcode-decoded.
- Output register:
  - If loaded at an edge, out_valid=1.
  - Else if out_valid && out_ready, out_valid=0 and data fields keep their last value.
  - Else unchanged.
- Latency: one falling edge from accepting the last word of an instruction to out_valid=1. Full throughput (one instruction per cycle) when out_ready is held 1.
- Back-pressure: while out_valid=1 and out_ready=0, the output fields are stable and in_ready=0.
- flush=1 at an edge: state=S_OPC, hold registers cleared, out_valid=0, no accept, illegal_count unchanged.
  - flush takes priority over accept and over out_ready.
  - flush in S_IMM discards the pending opcode.
- reset_n asserted mid two-word instruction: the pending opcode is lost. The next accepted word is decoded as an opcode.
- in_valid while in_ready=0 is ignored; the source must hold its word.

Test Plan (defaults):
1. Reset, then instructie=9'b0010_00011 with in_valid=1 and out_ready=1 → next edge: out_valid=1, out_code=3, out_operand=3, out_has_imm=0, out_illegal=0.
2. Opcodes 0,1,2,3,4 presented back-to-back with out_ready=1 → out_code sequence 1,2,3,4,5 on consecutive edges, and in_ready stays 1.
3. 9'b0110_00101 (op 6, needs immediate), then 9'h1A5 → after the first edge out_valid=0 and state=S_IMM; after the second edge out_code=7, out_operand=5, out_imm=9'h1A5, out_has_imm=1.
4. 9'b1001_00000 (op 9, illegal) presented 300 times with out_ready=1 → out_code=0 and out_illegal=1 each time; illegal_count reaches 255 and holds.
5. out_ready=0 after one decode → in_ready=0 and outputs stable for 5 cycles. Raising out_ready → out_valid drops (or is reloaded) on the next edge.
6. op 5 accepted (now in S_IMM), then flush=1 for one cycle, then 9'b0001_00010 → no output from op 5; out_code=2, out_operand=2, out_has_imm=0. Repeat with reset_n pulsed instead of flush → same result, with all outputs 0 during reset.

Source files
------------

// File: rtl/instructie_decoder_pipe.sv
// Handshaked instruction decoder: opcode k -> code k+1 (0 = illegal), optional trailing immediate word.
// One falling edge from last accepted word to out_valid; in_ready drops while a full output is stalled.
module instructie_decoder_pipe #(
    parameter int                     INSTR_W  = 9,
    parameter int                     OPC_W    = 4,
    parameter int                     NUM_OPS  = 7,
    parameter logic [2**OPC_W-1:0]    IMM_MASK = 16'h0060,
    parameter int                     CNT_W    = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         instructie,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPC_W:0]             out_code,
    output logic [INSTR_W-OPC_W-1:0]   out_operand,
    output logic [INSTR_W-1:0]         out_imm,
    output logic                       out_has_imm,
    output logic                       out_illegal,
    output logic [CNT_W-1:0]           illegal_count
);

    localparam int             OPR_W      = INSTR_W - OPC_W;
    localparam logic [OPC_W:0] NUM_OPS_V  = (OPC_W+1)'(NUM_OPS);

    typedef enum logic {S_OPC, S_IMM} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [OPC_W-1:0]     r_hold_op;
    logic [OPR_W-1:0]     r_hold_operand;
    logic                 r_out_valid;
    logic [OPC_W:0]       r_out_code;
    logic [OPR_W-1:0]     r_out_operand;
    logic [INSTR_W-1:0]   r_out_imm;
    logic                 r_out_has_imm;
    logic                 r_out_illegal;
    logic [CNT_W-1:0]     r_illegal_count;

    logic [OPC_W-1:0]     w_op;
    logic [OPR_W-1:0]     w_operand;
    logic                 w_accept;
    logic                 w_op_illegal;
    logic                 w_load;
    logic                 w_hold_en;
    logic                 w_cnt_inc;
    logic [OPC_W:0]       w_code;
    logic [OPR_W-1:0]     w_out_operand;
    logic [INSTR_W-1:0]   w_imm;
    logic                 w_has_imm;
    logic                 w_illegal;

    assign w_op         = instructie[INSTR_W-1 -: OPC_W];
    assign w_operand    = instructie[OPR_W-1:0];
    assign in_ready     = !flush && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_op_illegal = ({1'b0, w_op} >= NUM_OPS_V);

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_hold_en     = 1'b0;
        w_cnt_inc     = 1'b0;
        w_code        = '0;
        w_out_operand = w_operand;
        w_imm         = '0;
        w_has_imm     = 1'b0;
        w_illegal     = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_OPC: begin
                    if (w_op_illegal) begin
                        w_load    = 1'b1;
                        w_illegal = 1'b1;
                        w_cnt_inc = 1'b1;
                    end else if (IMM_MASK[w_op]) begin
                        w_hold_en   = 1'b1;
                        w_state_nxt = S_IMM;
                    end else begin
                        w_load = 1'b1;
                        w_code = {1'b0, w_op} + (OPC_W+1)'(1);
                    end
                end
                S_IMM: begin
                    // The immediate word is passed through untouched, never opcode-decoded.
                    w_load        = 1'b1;
                    w_code        = {1'b0, r_hold_op} + (OPC_W+1)'(1);
                    w_out_operand = r_hold_operand;
                    w_imm         = instructie;
                    w_has_imm     = 1'b1;
                    w_state_nxt   = S_OPC;
                end
                default: w_state_nxt = S_OPC;
            endcase
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_OPC;
            r_hold_op      <= '0;
            r_hold_operand <= '0;
        end else if (flush) begin
            r_state        <= S_OPC;
            r_hold_op      <= '0;
            r_hold_operand <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hold_en) begin
                r_hold_op      <= w_op;
                r_hold_operand <= w_operand;
            end
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid   <= 1'b0;
            r_out_code    <= '0;
            r_out_operand <= '0;
            r_out_imm     <= '0;
            r_out_has_imm <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_out_code    <= w_code;
            r_out_operand <= w_out_operand;
            r_out_imm     <= w_imm;
            r_out_has_imm <= w_has_imm;
            r_out_illegal <= w_illegal;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal_count <= '0;
        end else if (w_cnt_inc && (r_illegal_count != {CNT_W{1'b1}})) begin
            r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    assign out_valid     = r_out_valid;
    assign out_code      = r_out_code;
    assign out_operand   = r_out_operand;
    assign out_imm       = r_out_imm;
    assign out_has_imm   = r_out_has_imm;
    assign out_illegal   = r_out_illegal;
    assign illegal_count = r_illegal_count;

endmodule

// File: tb/tb_instructie_decoder_pipe.sv
// Directed plus random stimulus against a cycle-level reference of the decoder's instruction semantics.
module tb_instructie_decoder_pipe;

    logic       clock = 1'b1;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] instructie;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_code;
    logic [4:0] out_operand;
    logic [8:0] out_imm;
    logic       out_has_imm;
    logic       out_illegal;
    logic [7:0] illegal_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the consumer should see, plus a pending first half of a two-word instruction.
    bit         m_pend;
    int         m_hop;
    int         m_hopd;
    bit         m_vld;
    int         m_code;
    int         m_opd;
    int         m_imm;
    bit         m_has;
    bit         m_ill;
    int         m_cnt;
    logic [15:0] imm_mask = 16'h0060;

    always #5 clock = ~clock;

    instructie_decoder_pipe dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instructie   (instructie),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_operand  (out_operand),
        .out_imm      (out_imm),
        .out_has_imm  (out_has_imm),
        .out_illegal  (out_illegal),
        .illegal_count(illegal_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, int'(out_valid), int'(m_vld));
        check({tag, ".illegal_count"}, int'(illegal_count), m_cnt);
        if (m_vld) begin
            check({tag, ".out_code"}, int'(out_code), m_code);
            check({tag, ".out_operand"}, int'(out_operand), m_opd);
            check({tag, ".out_imm"}, int'(out_imm), m_imm);
            check({tag, ".out_has_imm"}, int'(out_has_imm), int'(m_has));
            check({tag, ".out_illegal"}, int'(out_illegal), int'(m_ill));
        end
    endtask

    // One clock cycle: drive, check in_ready, advance the reference, let the DUT take its edge, compare.
    task automatic cyc(input string tag, input bit v, input int w, input bit rdy, input bit fl);
        bit ready;
        bit acc;
        bit load;
        int op;
        in_valid   = v;
        instructie = w[8:0];
        out_ready  = rdy;
        flush      = fl;
        #1;
        ready = !fl && (!m_vld || rdy);
        acc   = v && ready;
        check({tag, ".in_ready"}, int'(in_ready), int'(ready));
        if (fl) begin
            m_pend = 0;
            m_vld  = 0;
        end else begin
            load = 0;
            if (acc) begin
                if (m_pend) begin
                    load = 1; m_code = m_hop + 1; m_opd = m_hopd;
                    m_imm = w % 512; m_has = 1; m_ill = 0; m_pend = 0;
                end else begin
                    op = (w % 512) / 32;
                    if (op >= 7) begin
                        load = 1; m_code = 0; m_opd = w % 32; m_imm = 0; m_has = 0; m_ill = 1;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end else if (imm_mask[op]) begin
                        m_pend = 1; m_hop = op; m_hopd = w % 32;
                    end else begin
                        load = 1; m_code = op + 1; m_opd = w % 32; m_imm = 0; m_has = 0; m_ill = 0;
                    end
                end
            end
            if (load) m_vld = 1;
            else if (m_vld && rdy) m_vld = 0;
        end
        @(negedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 0; flush = 0; out_ready = 1; instructie = '0;
        reset_n = 0;
        #1;
        m_pend = 0; m_vld = 0; m_code = 0; m_opd = 0; m_imm = 0; m_has = 0; m_ill = 0; m_cnt = 0;
        check({tag, ".rst.out_valid"}, int'(out_valid), 0);
        check({tag, ".rst.out_code"}, int'(out_code), 0);
        check({tag, ".rst.out_operand"}, int'(out_operand), 0);
        check({tag, ".rst.out_imm"}, int'(out_imm), 0);
        check({tag, ".rst.out_has_imm"}, int'(out_has_imm), 0);
        check({tag, ".rst.out_illegal"}, int'(out_illegal), 0);
        check({tag, ".rst.illegal_count"}, int'(illegal_count), 0);
        check({tag, ".rst.in_ready"}, int'(in_ready), 1);
        @(negedge clock);
        #2;
        reset_n = 1;
        #1;
    endtask

    initial begin
        reset_n = 0; flush = 0; in_valid = 0; out_ready = 0; instructie = '0;
        do_reset("t1");

        cyc("t1", 1, 9'b0010_00011, 1, 0);
        check("t1.code3", int'(out_code), 3);

        for (int k = 0; k < 5; k++) cyc("t2", 1, (k << 5) | k, 1, 0);
        check("t2.last_code", int'(out_code), 5);

        cyc("t3a", 1, 9'b0110_00101, 1, 0);
        check("t3a.no_out", int'(out_valid), 0);
        cyc("t3b", 1, 9'h1A5, 1, 0);
        check("t3b.imm", int'(out_imm), 9'h1A5);

        for (int k = 0; k < 300; k++) cyc("t4", 1, 9'b1001_00000, 1, 0);
        check("t4.sat", int'(illegal_count), 255);

        cyc("t5a", 1, 9'b0001_00111, 1, 0);
        for (int k = 0; k < 5; k++) cyc("t5stall", 1, 9'b0011_00001, 0, 0);
        cyc("t5b", 0, 0, 1, 0);

        cyc("t6a", 1, 9'b0101_01010, 1, 0);
        cyc("t6flush", 1, 9'b0010_00000, 1, 1);
        cyc("t6b", 1, 9'b0001_00010, 1, 0);
        check("t6b.code", int'(out_code), 2);

        cyc("t6c", 1, 9'b0101_01010, 1, 0);
        do_reset("t6r");
        cyc("t6d", 1, 9'b0001_00010, 1, 0);
        check("t6d.has_imm", int'(out_has_imm), 0);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd");
            cyc("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, 511)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
